// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data-memory load/store controller.
// Sizes follow the pipeline encoding; lane masks are little-endian byte enables.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } state_t;

  // Illegal size is folded in here so callers only need the range test on top.
  function automatic logic misaligned(input size_t sz, input logic [1:0] a);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = |a;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_mask(input size_t sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << a;
      SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment: extracts and extends loaded bytes/halves, and
// merges sub-word store data into a previously read word.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] word_i,
  input  logic [n-1:0] wdata_i,
  input  logic [1:0]   addr_lo_i,
  input  size_t        size_i,
  input  logic         unsigned_i,
  output logic [n-1:0] load_o,
  output logic [n-1:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [3:0]  mask;
  logic [31:0] rep;

  assign byte_lane = word_i[8*addr_lo_i +: 8];
  assign half_lane = word_i[16*addr_lo_i[1] +: 16];
  assign mask      = lane_mask(size_i, addr_lo_i);

  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{(n-8){byte_lane[7] & ~unsigned_i}}, byte_lane};
      SZ_HALF: load_o = {{(n-16){half_lane[15] & ~unsigned_i}}, half_lane};
      default: load_o = word_i;
    endcase
  end

  // Replicating the store data lets each enabled lane pick its bytes directly.
  always_comb begin
    rep = (size_i == SZ_BYTE) ? {4{wdata_i[7:0]}} : {2{wdata_i[15:0]}};
    merge_o = word_i;
    if (size_i == SZ_WORD) begin
      merge_o = wdata_i;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (mask[j]) merge_o[8*j +: 8] = rep[8*j +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store controller between the memory stage and a combinational-read dmem.
// Sub-word stores are done as read-modify-write; errors respond without strobes.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int n = 32,
  parameter int r = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_re,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata
);

  state_t       state_q, state_d;
  logic         write_q, write_d;
  size_t        size_q, size_d;
  logic         uns_q, uns_d;
  logic [r+1:0] addr_q, addr_d;
  logic [n-1:0] wdata_q, wdata_d;
  logic [n-1:0] word_q, word_d;
  logic [n-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;

  logic         req_err;
  logic [n-1:0] align_word;
  logic [n-1:0] load_val;
  logic [n-1:0] merge_val;

  assign req_err = misaligned(size_t'(req_size), req_addr[1:0]) | (|req_addr[n-1:r+2]);

  // In RD the lane logic sees live dmem data; in WR it merges the captured word.
  assign align_word = (state_q == RD) ? mem_rdata : word_q;

  dmem_lane_align #(.n(n)) u_align (
    .word_i     (align_word),
    .wdata_i    (wdata_q),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .load_o     (load_val),
    .merge_o    (merge_val)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          size_d  = size_t'(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr[r+1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_err;
          if (req_err)                          state_d = RSP;
          else if (!req_write)                  state_d = RD;
          else if (size_t'(req_size) == SZ_WORD) state_d = WR;
          else                                  state_d = RD;
        end
      end
      RD: begin
        word_d = mem_rdata;
        if (write_q) begin
          state_d = WR;
        end else begin
          rdata_d = load_val;
          state_d = RSP;
        end
      end
      WR: state_d = RSP;
      RSP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RSP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_re     = (state_q == RD);
  assign mem_we     = (state_q == WR);
  assign mem_addr   = {{(n-2*r){1'b0}}, addr_q[r+1:2], {r{1'b0}}};
  assign mem_wdata  = mem_we ? merge_val : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a 64-word behavioural dmem.
// Word index sits at mem_addr[2r-1:r] given the controller's address layout.
module tb_dmem_access_ctrl;

  localparam int N = 32;
  localparam int R = 6;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_rdata;
  logic         resp_err;
  logic         mem_re;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;

  logic [31:0] mem [64];

  int n_pass;
  int n_chk;

  int          res_lat;
  int          res_re;
  int          res_we;
  logic        res_overlap;
  logic [31:0] res_addr;
  logic [31:0] res_wd;
  logic [31:0] res_rdata;
  logic [31:0] res_err;

  dmem_access_ctrl #(.n(N), .r(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[2*R-1:R]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[2*R-1:R]] <= mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"},  {31'd0, req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_err"},   {31'd0, resp_err},   32'd0);
    check({tag, "_resp_rdata"}, resp_rdata,          32'd0);
    check({tag, "_mem_re"},     {31'd0, mem_re},     32'd0);
    check({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
    check({tag, "_mem_addr"},   mem_addr,            32'd0);
    check({tag, "_mem_wdata"},  mem_wdata,           32'd0);
  endtask

  // Issues one request, tracks strobes until resp_valid, optionally stalls the
  // response for 'hold' cycles, then completes the handshake.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input int hold);
    logic got;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    res_lat = 0; res_re = 0; res_we = 0; res_overlap = 1'b0;
    res_addr = '0; res_wd = '0; got = 1'b0;
    while (!got && res_lat < 10) begin
      @(negedge clk);
      res_lat++;
      if (mem_re && mem_we) res_overlap = 1'b1;
      if (mem_re) begin res_re++; res_addr = mem_addr; end
      if (mem_we) begin res_we++; res_addr = mem_addr; res_wd = mem_wdata; end
      if (resp_valid) got = 1'b1;
    end
    if (!got) check("resp_timeout", {31'd0, resp_valid}, 32'd1);
    res_rdata = resp_rdata;
    res_err   = {31'd0, resp_err};
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_resp_rdata", resp_rdata, res_rdata);
      check("hold_req_ready",  {31'd0, req_ready},  32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic expect_err(input string tag);
    check({tag, "_err"},     res_err,     32'd1);
    check({tag, "_lat"},     res_lat,     32'd1);
    check({tag, "_strobes"}, res_re + res_we, 32'd0);
    check({tag, "_rdata"},   res_rdata,   32'd0);
  endtask

  initial begin
    n_pass = 0; n_chk = 0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Word store then word load.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    check("wst_lat",   res_lat,   32'd2);
    check("wst_we",    res_we,    32'd1);
    check("wst_re",    res_re,    32'd0);
    check("wst_addr",  res_addr,  32'h100);
    check("wst_wdata", res_wd,    32'hDEADBEEF);
    check("wst_err",   res_err,   32'd0);
    check("wst_rdata", res_rdata, 32'd0);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("wld_lat",   res_lat,   32'd2);
    check("wld_re",    res_re,    32'd1);
    check("wld_we",    res_we,    32'd0);
    check("wld_rdata", res_rdata, 32'hDEADBEEF);
    check("wld_err",   res_err,   32'd0);

    // Byte store: only lane 1 replaced.
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234565A, 0);
    check("bst_lat",     res_lat, 32'd3);
    check("bst_re",      res_re,  32'd1);
    check("bst_we",      res_we,  32'd1);
    check("bst_overlap", {31'd0, res_overlap}, 32'd0);
    check("bst_wdata",   res_wd,  32'hDEAD5AEF);

    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("wld2_rdata", res_rdata, 32'hDEAD5AEF);

    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    check("lb_s_rdata", res_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    check("lb_u_rdata", res_rdata, 32'h000000DE);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0);
    check("lh_s_rdata", res_rdata, 32'hFFFFDEAD);
    check("lh_s_lat",   res_lat,   32'd2);

    // Error cases respond in one cycle with no memory strobes.
    do_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 0);
    expect_err("err_half_mis");
    do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, 0);
    expect_err("err_word_mis");
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    expect_err("err_size");
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0);
    expect_err("err_range");
    check("err_mem_intact", mem[4], 32'hDEAD5AEF);

    // Response held off for five cycles.
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    check("stall_rdata", res_rdata, 32'hDEAD5AEF);
    check("stall_lat",   res_lat,   32'd2);

    // Reset while a sub-word store sits in WR.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_rd", {31'd0, mem_re}, 32'd1);
    @(negedge clk);
    check("rst_mid_wr", {31'd0, mem_we}, 32'd1);
    #1 reset = 1'b1;
    #1 check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mem_word", mem[4], 32'hDEAD5AEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("rst_reload", res_rdata, 32'hDEAD5AEF);

    // Half store to upper lane, then readback.
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 0);
    check("hst_lat",   res_lat, 32'd3);
    check("hst_wdata", res_wd,  32'h12345AEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    check("hst_reload", res_rdata, 32'h12345AEF);
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 0);
    check("lb_u_lane0", res_rdata, 32'h000000EF);
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0);
    check("lh_u_lane1", res_rdata, 32'h00001234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
